// File: rtl/mskrnd_feeder.sv
// mskrnd_feeder: consumer end of the PRNG output stream. Buffers PRNG words
// in a small show-ahead FIFO, hands one word per cycle to the masked AES
// round logic, and schedules PRNG reseeds (periodic or host-requested).
//
// Ports
//   clk, nrst          clock, asynchronous active-low reset
//   prng_out_valid     PRNG word valid
//   prng_out_rnd       PRNG word (RND bits)
//   prng_out_ready     feeder accepts the word this cycle
//   prng_busy          PRNG is initialising or reseeding
//   prng_start_reseed  one-cycle reseed pulse to the PRNG
//   host_reseed_req    one-cycle request for an immediate reseed
//   core_rnd_req       core consumes a word this cycle
//   core_rnd           head-of-FIFO word (show-ahead)
//   core_rnd_valid     core_rnd holds an unconsumed word
//   fill_level         number of words stored
//   reseeding          high while a reseed is being requested / awaited
//   underflow          sticky: core_rnd_req seen with no valid word
module mskrnd_feeder #(
  parameter int unsigned RND           = 640,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned RESEED_PERIOD = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     prng_out_valid,
  input  logic [RND-1:0]           prng_out_rnd,
  output logic                     prng_out_ready,
  input  logic                     prng_busy,
  output logic                     prng_start_reseed,
  input  logic                     host_reseed_req,
  input  logic                     core_rnd_req,
  output logic [RND-1:0]           core_rnd,
  output logic                     core_rnd_valid,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     reseeding,
  output logic                     underflow
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam bit          AUTO_RESEED = (RESEED_PERIOD != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESEED_PERIOD - 1);

  // Elaboration-time parameter sanity
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mskrnd_feeder: DEPTH must be a power of two and at least 2");
  end
  if (AUTO_RESEED && (64'(RESEED_PERIOD) >= (64'(1) << CNT_W))) begin : g_bad_cnt
    $error("mskrnd_feeder: CNT_W too narrow for RESEED_PERIOD");
  end

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RSD_REQ  = 2'd1,
    ST_RSD_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                saw_busy_q, saw_busy_d;
  logic                flush;

  logic [RND-1:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0]   count_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                underflow_q;

  logic                run, full, empty;
  logic                wr_en, rd_en;

  // Handshake decode
  assign run   = (state_q == ST_RUN);
  assign full  = (count_q == FILL_W'(DEPTH));
  assign empty = (count_q == '0);

  // Ready is forced low while nrst is asserted so every output reads 0 in reset
  assign prng_out_ready    = nrst & run & ~full & ~prng_busy;
  assign core_rnd_valid    = run & ~empty;
  assign wr_en             = prng_out_valid & prng_out_ready;
  assign rd_en             = core_rnd_req & core_rnd_valid;

  assign core_rnd          = mem_q[rd_ptr_q];
  assign fill_level        = count_q;
  assign reseeding         = (state_q != ST_RUN);
  assign prng_start_reseed = (state_q == ST_RSD_REQ);
  assign underflow         = underflow_q;

  // Reseed FSM: state register
  always_ff @(posedge clk or negedge nrst) begin : p_state
    if (!nrst) begin
      state_q    <= ST_RUN;
      saw_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      saw_busy_q <= saw_busy_d;
    end
  end

  // Reseed FSM: next state and flush strobe
  always_comb begin : p_next
    state_d    = state_q;
    saw_busy_d = saw_busy_q;
    flush      = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        // Both triggers in one cycle still produce a single reseed
        if (host_reseed_req || (AUTO_RESEED && rd_en && (cnt_q == CNT_LAST))) begin
          state_d = ST_RSD_REQ;
        end
      end
      ST_RSD_REQ: begin
        flush      = 1'b1;
        saw_busy_d = 1'b0;
        state_d    = ST_RSD_WAIT;
      end
      ST_RSD_WAIT: begin
        // Leave only once the PRNG has visibly gone busy and come back
        if (prng_busy) begin
          saw_busy_d = 1'b1;
        end
        if (saw_busy_q && !prng_busy) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Word storage; cleared on reset so core_rnd reads 0
  always_ff @(posedge clk or negedge nrst) begin : p_mem
    if (!nrst) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= prng_out_rnd;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or negedge nrst) begin : p_ptr
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (flush) begin
        rd_ptr_q <= wr_ptr_q;
      end else if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Occupancy; a simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or negedge nrst) begin : p_count
    if (!nrst) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (wr_en && !rd_en) begin
      count_q <= count_q + FILL_W'(1);
    end else if (rd_en && !wr_en) begin
      count_q <= count_q - FILL_W'(1);
    end
  end

  // Consumed-word counter driving the periodic reseed
  always_ff @(posedge clk or negedge nrst) begin : p_cnt
    if (!nrst) begin
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (rd_en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Sticky underflow flag
  always_ff @(posedge clk or negedge nrst) begin : p_uflow
    if (!nrst) begin
      underflow_q <= 1'b0;
    end else if (core_rnd_req && !core_rnd_valid) begin
      underflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mskrnd_feeder.sv
// tb_mskrnd_feeder: directed bench for mskrnd_feeder with a queue-based
// reference model (main instance, RESEED_PERIOD=8) plus an ordering check on
// a second instance with automatic reseed disabled.
module tb_mskrnd_feeder;

  localparam int unsigned RND    = 640;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PERIOD = 8;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic           prng_out_valid = 1'b0;
  logic [RND-1:0] prng_out_rnd   = '0;
  logic           prng_out_ready;
  logic           prng_busy      = 1'b0;
  logic           prng_start_reseed;
  logic           host_reseed_req = 1'b0;
  logic           core_rnd_req    = 1'b0;
  logic [RND-1:0] core_rnd;
  logic           core_rnd_valid;
  logic [2:0]     fill_level;
  logic           reseeding;
  logic           underflow;

  // Second instance (automatic reseed disabled)
  logic           z_valid = 1'b0;
  logic [RND-1:0] z_rnd_in = '0;
  logic           z_ready;
  logic           z_start;
  logic           z_req = 1'b0;
  logic [RND-1:0] z_rnd;
  logic           z_rnd_valid;
  logic [2:0]     z_fill;
  logic           z_reseeding;
  logic           z_underflow;

  mskrnd_feeder #(.RND(RND), .DEPTH(DEPTH), .RESEED_PERIOD(PERIOD), .CNT_W(16)) dut (
    .clk(clk), .nrst(nrst),
    .prng_out_valid(prng_out_valid), .prng_out_rnd(prng_out_rnd), .prng_out_ready(prng_out_ready),
    .prng_busy(prng_busy), .prng_start_reseed(prng_start_reseed), .host_reseed_req(host_reseed_req),
    .core_rnd_req(core_rnd_req), .core_rnd(core_rnd), .core_rnd_valid(core_rnd_valid),
    .fill_level(fill_level), .reseeding(reseeding), .underflow(underflow)
  );

  mskrnd_feeder #(.RND(RND), .DEPTH(DEPTH), .RESEED_PERIOD(0), .CNT_W(16)) dut0 (
    .clk(clk), .nrst(nrst),
    .prng_out_valid(z_valid), .prng_out_rnd(z_rnd_in), .prng_out_ready(z_ready),
    .prng_busy(1'b0), .prng_start_reseed(z_start), .host_reseed_req(1'b0),
    .core_rnd_req(z_req), .core_rnd(z_rnd), .core_rnd_valid(z_rnd_valid),
    .fill_level(z_fill), .reseeding(z_reseeding), .underflow(z_underflow)
  );

  function automatic logic [RND-1:0] mkword(int k);
    return {32'(k) ^ 32'hC0DE_0000, 576'(0), 32'(k)};
  endfunction

  // PRNG source: offers words src_idx..src_lim in order, holding each until taken
  int   src_idx = 1;
  int   src_lim = 0;
  logic src_acc = 1'b0;
  always @(negedge clk) src_acc = prng_out_valid && prng_out_ready;
  always @(posedge clk) begin
    #2;
    if (src_acc) src_idx++;
    prng_out_valid = (src_idx <= src_lim);
    prng_out_rnd   = mkword(src_idx);
  end

  // Source for the second instance: unbounded stream once enabled
  int   z_idx = 1;
  bit   z_en  = 1'b0;
  logic z_acc = 1'b0;
  always @(negedge clk) z_acc = z_valid && z_ready;
  always @(posedge clk) begin
    #2;
    if (z_acc) z_idx++;
    z_valid  = z_en;
    z_rnd_in = mkword(z_idx);
  end

  // PRNG busy behaviour: busy for 5 cycles starting the cycle after a reseed pulse
  always @(negedge clk) begin
    if (prng_start_reseed) begin
      @(posedge clk);
      #1 prng_busy = 1'b1;
      repeat (5) @(posedge clk);
      #1 prng_busy = 1'b0;
    end
  end

  // Reference model: FIFO contents as a queue, reseed phase as two flags
  logic [RND-1:0] mq[$];
  bit             m_req_cyc = 1'b0;
  bit             m_waiting = 1'b0;
  bit             m_saw     = 1'b0;
  bit             m_uf      = 1'b0;
  int unsigned    m_reads   = 0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mq.delete();
      m_req_cyc = 1'b0;
      m_waiting = 1'b0;
      m_saw     = 1'b0;
      m_uf      = 1'b0;
      m_reads   = 0;
    end else begin
      bit run, have, wr, rd, trig;
      run  = !m_req_cyc && !m_waiting;
      have = run && (mq.size() > 0);
      wr   = prng_out_valid && run && (mq.size() < DEPTH) && !prng_busy;
      rd   = core_rnd_req && have;
      if (core_rnd_req && !have) m_uf = 1'b1;
      if (m_req_cyc) begin
        mq.delete();
        m_reads   = 0;
        m_saw     = 1'b0;
        m_req_cyc = 1'b0;
        m_waiting = 1'b1;
      end else if (m_waiting) begin
        if (m_saw && !prng_busy) m_waiting = 1'b0;
        if (prng_busy) m_saw = 1'b1;
      end else begin
        trig = host_reseed_req || (rd && (m_reads == PERIOD - 1));
        if (rd) begin
          void'(mq.pop_front());
          m_reads++;
        end
        if (wr) mq.push_back(prng_out_rnd);
        if (trig) m_req_cyc = 1'b1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  int n_rsd = 0;
  int z_starts = 0;
  int z_reads = 0;
  int z_next = 1;
  bit ord_en = 1'b0;
  int ord_next = 0;

  task automatic chk(string nm, logic [RND-1:0] act, logic [RND-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_cmp();
    bit run;
    int sz;
    run = !m_req_cyc && !m_waiting;
    sz  = mq.size();
    chk("ready",     RND'(prng_out_ready),    RND'(nrst && run && (sz < DEPTH) && !prng_busy));
    chk("valid",     RND'(core_rnd_valid),    RND'(run && (sz > 0)));
    chk("fill",      RND'(fill_level),        RND'(sz));
    chk("reseeding", RND'(reseeding),         RND'(!run));
    chk("start",     RND'(prng_start_reseed), RND'(m_req_cyc));
    chk("underflow", RND'(underflow),         RND'(m_uf));
    if (run && sz > 0) chk("core_rnd", core_rnd, mq[0]);
  endtask

  // One clock: compare at the falling edge, return just after the rising edge
  task automatic tick();
    @(negedge clk);
    model_cmp();
    if (prng_start_reseed) n_start++;
    if (reseeding) n_rsd++;
    if (z_start) z_starts++;
    if (ord_en && core_rnd_req && core_rnd_valid) begin
      chk("order", core_rnd, mkword(ord_next));
      ord_next++;
    end
    if (z_req && z_rnd_valid) begin
      chk("z_order", z_rnd, mkword(z_next));
      z_next++;
      z_reads++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic reset_dut();
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic lit(string nm, logic [RND-1:0] act, logic [RND-1:0] exp);
    chk(nm, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int base, s0, r0;

    // Reset state
    repeat (2) tick();
    settle();
    lit("rst_fill", RND'(fill_level), RND'(0));
    lit("rst_rnd", core_rnd, RND'(0));
    lit("rst_ready", RND'(prng_out_ready), RND'(0));
    nrst = 1'b1;

    // 1: stream 5 words with no reads
    base = src_idx;
    src_lim = base + 4;
    repeat (6) tick();
    settle();
    lit("t1_fill4", RND'(fill_level), RND'(4));
    lit("t1_head", core_rnd, mkword(base));
    lit("t1_ready_full", RND'(prng_out_ready), RND'(0));
    lit("t1_w5_pending", RND'(src_idx), RND'(base + 4));
    core_rnd_req = 1'b1;
    tick();
    core_rnd_req = 1'b0;
    settle();
    lit("t1_fill3", RND'(fill_level), RND'(3));
    lit("t1_head2", core_rnd, mkword(base + 1));
    lit("t1_ready_again", RND'(prng_out_ready), RND'(1));
    tick();
    settle();
    lit("t1_w5_taken", RND'(fill_level), RND'(4));

    // 2: fill then read every cycle
    reset_dut();
    base = src_idx;
    src_lim = base + 19;
    repeat (6) tick();
    ord_next = base;
    ord_en = 1'b1;
    core_rnd_req = 1'b1;
    settle();
    lit("t2_ready_full_read", RND'(prng_out_ready), RND'(0));
    repeat (7) tick();
    core_rnd_req = 1'b0;
    settle();
    lit("t2_fill", RND'(fill_level), RND'(3));
    lit("t2_seen", RND'(ord_next), RND'(base + 7));
    ord_en = 1'b0;

    // 3: underflow is sticky
    src_lim = src_idx - 1;
    reset_dut();
    core_rnd_req = 1'b1;
    repeat (2) tick();
    core_rnd_req = 1'b0;
    settle();
    lit("t3_uf", RND'(underflow), RND'(1));
    lit("t3_fill0", RND'(fill_level), RND'(0));
    src_lim = src_idx + 2;
    repeat (6) tick();
    core_rnd_req = 1'b1;
    repeat (2) tick();
    core_rnd_req = 1'b0;
    settle();
    lit("t3_uf_stays", RND'(underflow), RND'(1));
    reset_dut();
    settle();
    lit("t3_uf_cleared", RND'(underflow), RND'(0));

    // 4: periodic reseed after 8 reads
    src_lim = src_idx + 30;
    repeat (6) tick();
    s0 = n_start;
    r0 = n_rsd;
    core_rnd_req = 1'b1;
    repeat (8) tick();
    core_rnd_req = 1'b0;
    settle();
    lit("t4_start", RND'(prng_start_reseed), RND'(1));
    tick();
    settle();
    lit("t4_start_gone", RND'(prng_start_reseed), RND'(0));
    lit("t4_flushed", RND'(fill_level), RND'(0));
    lit("t4_reseeding", RND'(reseeding), RND'(1));
    repeat (10) tick();
    settle();
    lit("t4_back_run", RND'(reseeding), RND'(0));
    lit("t4_pulses", RND'(n_start - s0), RND'(1));
    lit("t4_rsd_cycles", RND'(n_rsd - r0), RND'(7));

    // 5: host request coincident with the 8th read, and again during wait
    reset_dut();
    src_lim = src_idx + 30;
    repeat (6) tick();
    s0 = n_start;
    core_rnd_req = 1'b1;
    repeat (7) tick();
    host_reseed_req = 1'b1;
    tick();
    host_reseed_req = 1'b0;
    core_rnd_req = 1'b0;
    repeat (2) tick();
    host_reseed_req = 1'b1;
    tick();
    host_reseed_req = 1'b0;
    repeat (12) tick();
    settle();
    lit("t5_one_pulse", RND'(n_start - s0), RND'(1));
    lit("t5_back_run", RND'(reseeding), RND'(0));

    // 6a: async reset in the middle of a reseed wait
    src_lim = src_idx - 1;
    reset_dut();
    src_lim = src_idx + 1;
    repeat (5) tick();
    settle();
    lit("t6_two_words", RND'(fill_level), RND'(2));
    host_reseed_req = 1'b1;
    tick();
    host_reseed_req = 1'b0;
    settle();
    lit("t6_start", RND'(prng_start_reseed), RND'(1));
    repeat (2) tick();
    settle();
    lit("t6_waiting", RND'(reseeding), RND'(1));
    nrst = 1'b0;
    #1;
    lit("t6a_ready", RND'(prng_out_ready), RND'(0));
    lit("t6a_start", RND'(prng_start_reseed), RND'(0));
    lit("t6a_valid", RND'(core_rnd_valid), RND'(0));
    lit("t6a_reseeding", RND'(reseeding), RND'(0));
    lit("t6a_rnd", core_rnd, RND'(0));
    tick();
    nrst = 1'b1;
    settle();
    lit("t6a_run", RND'(reseeding), RND'(0));
    lit("t6a_fill", RND'(fill_level), RND'(0));

    // 6b: async reset in RUN with 2 words buffered and cnt nonzero
    src_lim = src_idx + 2;
    repeat (10) tick();
    core_rnd_req = 1'b1;
    tick();
    core_rnd_req = 1'b0;
    settle();
    lit("t6b_fill2", RND'(fill_level), RND'(2));
    nrst = 1'b0;
    #1;
    lit("t6b_ready", RND'(prng_out_ready), RND'(0));
    lit("t6b_fill", RND'(fill_level), RND'(0));
    lit("t6b_valid", RND'(core_rnd_valid), RND'(0));
    lit("t6b_rnd", core_rnd, RND'(0));
    tick();
    nrst = 1'b1;

    // 6c: counter restarted by reset: reseed only after 8 fresh reads
    src_lim = src_idx + 40;
    repeat (8) tick();
    s0 = n_start;
    core_rnd_req = 1'b1;
    repeat (7) tick();
    core_rnd_req = 1'b0;
    repeat (2) tick();
    settle();
    lit("t6c_no_early", RND'(n_start - s0), RND'(0));
    core_rnd_req = 1'b1;
    tick();
    core_rnd_req = 1'b0;
    settle();
    lit("t6c_start", RND'(prng_start_reseed), RND'(1));
    repeat (10) tick();
    lit("t6c_one_pulse", RND'(n_start - s0), RND'(1));

    // RESEED_PERIOD=0 instance: 2000 reads, never a reseed
    z_en = 1'b1;
    repeat (4) tick();
    z_req = 1'b1;
    for (int i = 0; i < 3000 && z_reads < 2000; i++) tick();
    z_req = 1'b0;
    settle();
    lit("z_reads", RND'(z_reads), RND'(2000));
    lit("z_no_reseed", RND'(z_starts), RND'(0));
    lit("z_no_uf", RND'(z_underflow), RND'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
